// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
//   Four-master round-robin arbiter and bus multiplexer for the shared CPU
//   system bus. One master owns the bus at a time. Its address, strobe,
//   direction and write data are routed to the single slave port. Read data and
//   ready come back to the owner only. A watchdog completes an access that the
//   slave never acknowledges, and it flags that access with a bus error pulse.
//
// Parameters
//   ADDR_W   word-address width
//   DATA_W   data width
//   TIMEOUT  maximum cycles from as_ to rdy_ before forced completion (0 = off)
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   m_req_     per-master request (active low)
//   m_addr     packed master addresses, master i at [i*ADDR_W +: ADDR_W]
//   m_as_      per-master address strobe (active low)
//   m_rw       per-master read(1)/write(0)
//   m_wr_data  packed master write data, master i at [i*DATA_W +: DATA_W]
//   m_grnt_    per-master grant (active low, registered)
//   m_rd_data  read data broadcast to all masters
//   m_rdy_     per-master ready (active low)
//   s_addr/s_as_/s_rw/s_wr_data  slave-side request from the current owner
//   s_rd_data/s_rdy_             slave response
//   owner      current owner index (held while idle)
//   bus_err    one-cycle pulse when the watchdog forces completion
// -----------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            m_req_,
  input  logic [4*ADDR_W-1:0]   m_addr,
  input  logic [3:0]            m_as_,
  input  logic [3:0]            m_rw,
  input  logic [4*DATA_W-1:0]   m_wr_data,
  output logic [3:0]            m_grnt_,
  output logic [DATA_W-1:0]     m_rd_data,
  output logic [3:0]            m_rdy_,
  output logic [ADDR_W-1:0]     s_addr,
  output logic                  s_as_,
  output logic                  s_rw,
  output logic [DATA_W-1:0]     s_wr_data,
  input  logic [DATA_W-1:0]     s_rd_data,
  input  logic                  s_rdy_,
  output logic [1:0]            owner,
  output logic                  bus_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit WD_EN = (TIMEOUT > 0);
  // A zero-width counter is illegal, so the disabled watchdog keeps one dummy bit.
  localparam int CNT_W = WD_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_t           state, state_n;
  logic [1:0]       owner_n;
  logic [1:0]       last, last_n;
  logic [3:0]       grnt_q, grnt_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic [3:0]       cand;
  logic [1:0]       win;
  logic             win_valid;
  logic             wd_hit;

  // ---------------------------------------------------------------------------
  // Round-robin search: the first candidate at or after last+1, wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    cand      = ~m_req_;
    win       = '0;
    win_valid = 1'b0;
    // A releasing owner must not win the same-cycle search.
    if (state == GRANT) cand[owner] = 1'b0;
    // Scan from the farthest offset to the nearest, so the nearest match wins.
    for (int k = 3; k >= 0; k--) begin
      if (cand[last + 2'd1 + 2'(k)]) begin
        win       = last + 2'd1 + 2'(k);
        win_valid = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    unique case (state)
      IDLE: begin
        if (win_valid) begin
          state_n = GRANT;
          owner_n = win;
          last_n  = win;
        end
      end
      GRANT: begin
        if (m_req_[owner]) begin
          if (win_valid) begin
            owner_n = win;
            last_n  = win;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    grnt_n = (state_n == GRANT) ? ~(4'b0001 << owner_n) : 4'b1111;
  end

  // ---------------------------------------------------------------------------
  // Slave mux and return path
  // ---------------------------------------------------------------------------
  always_comb begin
    s_addr    = '0;
    s_as_     = 1'b1;
    s_rw      = 1'b1;
    s_wr_data = '0;
    if (state == GRANT) begin
      s_addr    = m_addr[owner*ADDR_W +: ADDR_W];
      s_as_     = m_as_[owner];
      s_rw      = m_rw[owner];
      s_wr_data = m_wr_data[owner*DATA_W +: DATA_W];
    end
  end

  // A real rdy_ in the limit cycle wins over the forced completion.
  assign wd_hit  = WD_EN && (state == GRANT) && (cnt == CNT_LIMIT);
  assign bus_err = wd_hit && s_rdy_;

  always_comb begin
    m_rdy_ = 4'b1111;
    if (state == GRANT) m_rdy_[owner] = s_rdy_ & ~bus_err;
  end

  assign m_rd_data = bus_err ? '0 : s_rd_data;
  assign m_grnt_   = grnt_q;

  // ---------------------------------------------------------------------------
  // Watchdog: the counter starts on a strobe while the slave is not ready, keeps
  // counting while the slave stays not ready, and clears on a reply, on an owner
  // change, on idle, or after it forces completion.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_n = '0;
    if (WD_EN && state == GRANT && state_n == GRANT && owner_n == owner) begin
      if (!s_rdy_ || wd_hit)          cnt_n = '0;
      else if (cnt != '0 || !s_as_)   cnt_n = cnt + CNT_W'(1);
      else                            cnt_n = cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers (synchronous reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples the pre-edge values.
    if (!reset) begin
      state  <= IDLE;
      owner  <= 2'd0;
      last   <= 2'd3;
      grnt_q <= 4'b1111;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      last   <= last_n;
      grnt_q <= grnt_n;
      cnt    <= cnt_n;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_rr
//   Scoreboard bench for bus_arbiter_rr. Expected output values are queued as
//   stimulus is applied. They are compared once the outputs settle, at the
//   falling clock edge or 1 time unit after a purely combinational input change.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_rr;

  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [3:0]          m_req_;
  logic [4*ADDR_W-1:0] m_addr;
  logic [3:0]          m_as_;
  logic [3:0]          m_rw;
  logic [4*DATA_W-1:0] m_wr_data;
  logic [3:0]          m_grnt_;
  logic [DATA_W-1:0]   m_rd_data;
  logic [3:0]          m_rdy_;
  logic [ADDR_W-1:0]   s_addr;
  logic                s_as_;
  logic                s_rw;
  logic [DATA_W-1:0]   s_wr_data;
  logic [DATA_W-1:0]   s_rd_data;
  logic                s_rdy_;
  logic [1:0]          owner;
  logic                bus_err;

  bus_arbiter_rr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .m_req_    (m_req_),
    .m_addr    (m_addr),
    .m_as_     (m_as_),
    .m_rw      (m_rw),
    .m_wr_data (m_wr_data),
    .m_grnt_   (m_grnt_),
    .m_rd_data (m_rd_data),
    .m_rdy_    (m_rdy_),
    .s_addr    (s_addr),
    .s_as_     (s_as_),
    .s_rw      (s_rw),
    .s_wr_data (s_wr_data),
    .s_rd_data (s_rd_data),
    .s_rdy_    (s_rdy_),
    .owner     (owner),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  typedef enum {SIG_GRNT, SIG_OWNER, SIG_SADDR, SIG_SAS, SIG_SRW,
                SIG_SWDATA, SIG_RDY, SIG_ERR, SIG_RDATA} sig_e;

  typedef struct {
    sig_e        sig;
    logic [63:0] val;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input sig_e s, input logic [63:0] v, input string tag);
    exp_t e;
    e.sig = s;
    e.val = v;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  function automatic logic [63:0] observe(input sig_e s);
    case (s)
      SIG_GRNT:   return 64'(m_grnt_);
      SIG_OWNER:  return 64'(owner);
      SIG_SADDR:  return 64'(s_addr);
      SIG_SAS:    return 64'(s_as_);
      SIG_SRW:    return 64'(s_rw);
      SIG_SWDATA: return 64'(s_wr_data);
      SIG_RDY:    return 64'(m_rdy_);
      SIG_ERR:    return 64'(bus_err);
      default:    return 64'(m_rd_data);
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sig), e.val);
    end
  endtask

  // One clock edge, then compare everything queued for it.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  task automatic expect_grant(input logic [1:0] who, input string tag);
    logic [3:0] g;
    g = ~(4'b0001 << who);
    expect_out(SIG_GRNT, 64'(g), {tag, "_grnt"});
    expect_out(SIG_OWNER, 64'(who), {tag, "_owner"});
  endtask

  // Runaway guard: the bench is cycle-counted, so this should never expire.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    logic [1:0] cur, nxt;

    reset     = 1'b0;
    m_req_    = 4'hF;
    m_as_     = 4'hF;
    m_rw      = 4'hF;
    m_addr    = '0;
    m_wr_data = '0;
    s_rd_data = '0;
    s_rdy_    = 1'b1;
    @(negedge clk);

    // Reset state
    expect_out(SIG_GRNT,  64'hF, "rst_grnt");
    expect_out(SIG_OWNER, 64'h0, "rst_owner");
    expect_out(SIG_ERR,   64'h0, "rst_err");
    expect_out(SIG_SAS,   64'h1, "rst_sas");
    expect_out(SIG_SADDR, 64'h0, "rst_saddr");
    expect_out(SIG_RDY,   64'hF, "rst_rdy");
    step();

    // Master 0 single request: grant one edge later, address mirrored
    reset = 1'b1;
    m_req_ = 4'b1110;
    m_addr[0*ADDR_W +: ADDR_W] = 30'h100;
    expect_grant(2'd0, "m0");
    expect_out(SIG_SADDR, 64'h100, "m0_saddr");
    step();

    // Release: back to idle, owner held
    m_req_ = 4'hF;
    expect_out(SIG_GRNT,  64'hF, "idle_grnt");
    expect_out(SIG_OWNER, 64'h0, "idle_owner_held");
    expect_out(SIG_SAS,   64'h1, "idle_sas");
    step();

    // Fresh reset so last=3, then all four requesting
    reset = 1'b0;
    step();
    reset = 1'b1;
    m_req_ = 4'b0000;
    expect_grant(2'd0, "rr_first");
    step();

    // Each owner releases for one cycle: direct hand-off, then hold
    cur = 2'd0;
    for (int i = 0; i < 4; i++) begin
      nxt = cur + 2'd1;
      m_req_ = 4'b0000;
      m_req_[cur] = 1'b1;
      expect_grant(nxt, $sformatf("rr_pass%0d", i));
      step();
      m_req_ = 4'b0000;
      expect_grant(nxt, $sformatf("rr_hold%0d", i));
      step();
      cur = nxt;
    end

    // Master 1 write through the mux
    m_req_ = 4'b1101;
    expect_grant(2'd1, "m1");
    step();
    m_as_ = 4'b1101;
    m_rw  = 4'b1101;
    m_addr[1*ADDR_W +: ADDR_W]    = 30'h2A0;
    m_wr_data[1*DATA_W +: DATA_W] = 32'hDEADBEEF;
    #1;
    expect_out(SIG_SWDATA, 64'hDEADBEEF, "m1_swdata");
    expect_out(SIG_SADDR,  64'h2A0,      "m1_saddr");
    expect_out(SIG_SAS,    64'h0,        "m1_sas");
    expect_out(SIG_SRW,    64'h0,        "m1_srw");
    expect_out(SIG_RDY,    64'hF,        "m1_rdy_wait");
    drain();
    s_rdy_    = 1'b0;
    s_rd_data = 32'h12345678;
    #1;
    expect_out(SIG_RDY,   64'hD,        "m1_rdy");
    expect_out(SIG_RDATA, 64'h12345678, "m1_rdata");
    expect_out(SIG_ERR,   64'h0,        "m1_err");
    drain();
    step();
    m_as_  = 4'hF;
    s_rdy_ = 1'b1;
    step();

    // Master 2 hangs: watchdog fires after 16 cycles for exactly one cycle
    m_req_ = 4'b1011;
    expect_grant(2'd2, "m2");
    step();
    m_as_     = 4'b1011;
    s_rd_data = 32'hCAFE0001;
    for (int i = 1; i <= 16; i++) begin
      if (i < 16) begin
        expect_out(SIG_ERR, 64'h0, $sformatf("wd_quiet%0d", i));
        expect_out(SIG_RDY, 64'hF, $sformatf("wd_rdy%0d", i));
      end else begin
        expect_out(SIG_ERR,   64'h1, "wd_err");
        expect_out(SIG_RDY,   64'hB, "wd_rdy_forced");
        expect_out(SIG_RDATA, 64'h0, "wd_rdata_zero");
      end
      step();
    end
    expect_out(SIG_ERR,   64'h0,        "wd_err_one_cycle");
    expect_out(SIG_RDY,   64'hF,        "wd_rdy_after");
    expect_out(SIG_RDATA, 64'hCAFE0001, "wd_rdata_after");
    step();

    // Clear, then slave replies exactly on the limit cycle
    s_rdy_ = 1'b0;
    expect_out(SIG_RDY, 64'hB, "clr_rdy");
    step();
    s_rdy_ = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (i < 16) expect_out(SIG_ERR, 64'h0, $sformatf("race_quiet%0d", i));
      step();
    end
    s_rdy_    = 1'b0;
    s_rd_data = 32'h5A5A1234;
    #1;
    expect_out(SIG_ERR,   64'h0,        "race_err");
    expect_out(SIG_RDY,   64'hB,        "race_rdy");
    expect_out(SIG_RDATA, 64'h5A5A1234, "race_rdata");
    drain();
    expect_out(SIG_ERR, 64'h0, "race_after");
    step();
    m_as_  = 4'hF;
    s_rdy_ = 1'b1;

    // Reset during a master 3 access
    m_req_ = 4'b0111;
    expect_grant(2'd3, "m3");
    step();
    m_as_ = 4'b0111;
    #1;
    expect_out(SIG_SAS, 64'h0, "m3_sas");
    drain();
    reset = 1'b0;
    expect_out(SIG_GRNT,  64'hF, "mrst_grnt");
    expect_out(SIG_SAS,   64'h1, "mrst_sas");
    expect_out(SIG_ERR,   64'h0, "mrst_err");
    expect_out(SIG_OWNER, 64'h0, "mrst_owner");
    expect_out(SIG_RDY,   64'hF, "mrst_rdy");
    step();
    reset  = 1'b1;
    m_as_  = 4'hF;
    m_req_ = 4'b0000;
    expect_grant(2'd0, "mrst_rearb");
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
